mtl_pixel_source: RTL and testbench

MTL_PIXEL_SOURCE -- requirements
Module: mtl_pixel_source

---
 rtl/mtl_pixel_source.sv | 181 ++++++++++++++++++
 tb/tb_mtl_pixel_source.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtl_pixel_source.sv
// LCD pixel source: FIFO buffer between a pixel producer and the LCD controller.
// Optional colour-bar generator enabled by `define MTL_PIXEL_SOURCE_TESTPAT_EN.
module mtl_pixel_source #(
   parameter int unsigned FIFO_DEPTH   = 512,
   parameter int unsigned PREFILL      = 256,
   parameter int unsigned FRAME_PIXELS = 384000,
   parameter logic [23:0] FILL_COLOR   = 24'hFFFFFF
) (
   input  logic                            CLK_33,
   input  logic                            reset,
   input  logic                            wr_valid,
   input  logic [23:0]                     wr_data,
   output logic                            wr_ready,
   input  logic                            iREAD_SDRAM_EN,
   input  logic                            iNewFrame,
   input  logic                            iEndFrame,
`ifdef MTL_PIXEL_SOURCE_TESTPAT_EN
   input  logic                            test_mode,
`endif
   output logic [31:0]                     oREAD_DATA,
   output logic                            oUnderrun,
   output logic                            oFrameErr,
   output logic [$clog2(FIFO_DEPTH):0]     oLevel
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(FRAME_PIXELS + 2);

   localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
   localparam logic [CW-1:0] FRAME_L   = CW'(FRAME_PIXELS);
   localparam logic [CW-1:0] PIX_MAX   = CW'(FRAME_PIXELS + 1);
   localparam logic [31:0]   FILL_W    = {8'h00, FILL_COLOR};

   typedef enum logic [1:0] {
      WAIT_FILL,
      WAIT_FRAME,
      STREAM,
      RESYNC
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [CW-1:0] pix_q, pix_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          unr_q, unr_d;
   logic          ferr_q, ferr_d;

   logic [23:0]   mem [FIFO_DEPTH];
   logic [23:0]   head;
   logic [23:0]   pat_w;
   logic [CW-1:0] pix_inc;
   logic          push, pop, empty, tm;

   assign wr_ready = (level_q != DEPTH_L);
   assign empty    = (level_q == '0);
   assign push     = wr_valid && wr_ready;
   assign head     = mem[rd_ptr_q];
   assign pix_inc  = (pix_q == PIX_MAX) ? pix_q : pix_q + CW'(1);

`ifdef MTL_PIXEL_SOURCE_TESTPAT_EN
   function automatic logic [23:0] bar(input logic [CW-1:0] p);
      logic [31:0] col;
      col = (32'(p) % 32'd800) / 32'd100;
      case (col[2:0])
         3'd0:    bar = 24'hFFFFFF;
         3'd1:    bar = 24'hFFFF00;
         3'd2:    bar = 24'h00FFFF;
         3'd3:    bar = 24'h00FF00;
         3'd4:    bar = 24'hFF00FF;
         3'd5:    bar = 24'hFF0000;
         3'd6:    bar = 24'h0000FF;
         default: bar = 24'h000000;
      endcase
   endfunction

   assign tm    = test_mode;
   assign pat_w = bar(pix_q);
`else
   assign tm    = 1'b0;
   assign pat_w = FILL_COLOR;
`endif

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      drop_d  = drop_q;
      rdata_d = rdata_q;
      unr_d   = unr_q;
      ferr_d  = ferr_q;
      pop     = 1'b0;
      unique case (state_q)
         WAIT_FILL: begin
            if (iREAD_SDRAM_EN) rdata_d = FILL_W;
            if (level_q >= PREFILL_L) state_d = WAIT_FRAME;
         end
         WAIT_FRAME: begin
            if (iREAD_SDRAM_EN) rdata_d = FILL_W;
            if (iNewFrame) begin
               state_d = STREAM;
               pix_d   = '0;
            end
         end
         STREAM: begin
            if (iEndFrame && pix_q != FRAME_L) ferr_d = 1'b1;
            if (iREAD_SDRAM_EN) begin
               if (tm) begin
                  rdata_d = {8'h00, pat_w};
                  pix_d   = pix_inc;
               end else if (!empty) begin
                  pop     = 1'b1;
                  rdata_d = {8'h00, head};
                  pix_d   = pix_inc;
               end else begin
                  // same-cycle push is not forwarded; the frame is lost
                  rdata_d = FILL_W;
                  unr_d   = 1'b1;
                  drop_d  = (pix_q < FRAME_L) ?
                            FRAME_L - pix_q - CW'(1) : '0;
                  state_d = RESYNC;
               end
            end
            if (iNewFrame) pix_d = '0;
         end
         RESYNC: begin
            if (iREAD_SDRAM_EN) rdata_d = FILL_W;
            if (drop_q == '0) begin
               state_d = WAIT_FRAME;
            end else if (!empty) begin
               pop    = 1'b1;
               drop_d = drop_q - CW'(1);
            end
         end
         default: state_d = WAIT_FILL;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge CLK_33) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge CLK_33 or posedge reset) begin
      if (reset) begin
         state_q  <= WAIT_FILL;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         pix_q    <= '0;
         drop_q   <= '0;
         rdata_q  <= '0;
         unr_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         pix_q    <= pix_d;
         drop_q   <= drop_d;
         rdata_q  <= rdata_d;
         unr_q    <= unr_d;
         ferr_q   <= ferr_d;
      end
   end

   assign oREAD_DATA = rdata_q;
   assign oUnderrun  = unr_q;
   assign oFrameErr  = ferr_q;
   assign oLevel     = level_q;

endmodule

// File: tb/tb_mtl_pixel_source.sv
// Bench for mtl_pixel_source: queue-based behavioural model plus directed scenarios.
module tb_mtl_pixel_source;
   localparam int DEPTH = 8;
   localparam int PRE   = 4;
   localparam int FP    = 16;
   localparam logic [23:0] FILL = 24'hFFFFFF;
   localparam logic [31:0] FILLW = 32'h00FFFFFF;

   logic        CLK_33 = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic [23:0] wr_data = '0;
   logic        iREAD_SDRAM_EN = 1'b0;
   logic        iNewFrame = 1'b0;
   logic        iEndFrame = 1'b0;
   logic        wr_ready;
   logic [31:0] oREAD_DATA;
   logic        oUnderrun;
   logic        oFrameErr;
   logic [3:0]  oLevel;

   int checks = 0;
   int errors = 0;

   always #5 CLK_33 = ~CLK_33;

   mtl_pixel_source #(
      .FIFO_DEPTH(DEPTH),
      .PREFILL(PRE),
      .FRAME_PIXELS(FP),
      .FILL_COLOR(FILL)
   ) dut (
      .CLK_33(CLK_33),
      .reset(reset),
      .wr_valid(wr_valid),
      .wr_data(wr_data),
      .wr_ready(wr_ready),
      .iREAD_SDRAM_EN(iREAD_SDRAM_EN),
      .iNewFrame(iNewFrame),
      .iEndFrame(iEndFrame),
`ifdef MTL_PIXEL_SOURCE_TESTPAT_EN
      .test_mode(1'b0),
`endif
      .oREAD_DATA(oREAD_DATA),
      .oUnderrun(oUnderrun),
      .oFrameErr(oFrameErr),
      .oLevel(oLevel)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: mode 0 filling, 1 waiting frame, 2 streaming, 3 resync
   logic [23:0] q[$];
   int          mode;
   int          pix;
   int          drop;
   int          m_n;
   bit          m_full;
   logic [31:0] m_out;
   bit          m_unr;
   bit          m_ferr;

   always @(posedge CLK_33 or posedge reset) begin
      if (reset) begin
         q.delete();
         mode = 0; pix = 0; drop = 0;
         m_out = '0; m_unr = 0; m_ferr = 0;
      end else begin
         m_n = q.size();
         m_full = (m_n == DEPTH);
         case (mode)
            0: begin
               if (iREAD_SDRAM_EN) m_out = FILLW;
               if (m_n >= PRE) mode = 1;
            end
            1: begin
               if (iREAD_SDRAM_EN) m_out = FILLW;
               if (iNewFrame) begin mode = 2; pix = 0; end
            end
            2: begin
               if (iEndFrame && pix != FP) m_ferr = 1;
               if (iREAD_SDRAM_EN) begin
                  if (m_n > 0) begin
                     m_out = {8'h00, q.pop_front()};
                     if (pix < FP + 1) pix = pix + 1;
                  end else begin
                     m_out = FILLW;
                     m_unr = 1;
                     drop = (FP - pix - 1 > 0) ? FP - pix - 1 : 0;
                     mode = 3;
                  end
               end
               if (iNewFrame) pix = 0;
            end
            default: begin
               if (iREAD_SDRAM_EN) m_out = FILLW;
               if (drop == 0) mode = 1;
               else if (m_n > 0) begin
                  void'(q.pop_front());
                  drop = drop - 1;
               end
            end
         endcase
         if (wr_valid && !m_full) q.push_back(wr_data);
      end
   end

   always @(negedge CLK_33) begin
      if (!reset) begin
         chk("m_data", oREAD_DATA, m_out);
         chk("m_level", 32'(oLevel), 32'(q.size()));
         chk("m_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
         chk("m_underrun", 32'(oUnderrun), 32'(m_unr));
         chk("m_frameerr", 32'(oFrameErr), 32'(m_ferr));
      end
   end

   task automatic cyc(input logic v, input logic [23:0] d, input logic r,
                      input logic nf, input logic ef);
      wr_valid = v;
      wr_data = d;
      iREAD_SDRAM_EN = r;
      iNewFrame = nf;
      iEndFrame = ef;
      @(negedge CLK_33);
   endtask

   task automatic idle();
      cyc(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [23:0] d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic req();
      cyc(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic newframe();
      cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      wr_valid = 1'b0;
      iREAD_SDRAM_EN = 1'b0;
      iNewFrame = 1'b0;
      iEndFrame = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_data", oREAD_DATA, 32'h0);
      chk("rst_level", 32'(oLevel), 32'h0);
      chk("rst_flags", 32'({oUnderrun, oFrameErr}), 32'h0);
      @(negedge CLK_33);
      @(negedge CLK_33);
      reset = 1'b0;
      #1;
      chk("rst_ready", 32'(wr_ready), 32'h1);
      @(negedge CLK_33);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge CLK_33);
      // prefill not reached: new frame ignored, request gives fill colour
      do_reset();
      for (int i = 1; i <= 3; i++) push(24'(i));
      newframe();
      req();
      chk("prefill_data", oREAD_DATA, 32'h00FFFFFF);
      chk("prefill_level", 32'(oLevel), 32'd3);

      // full frame of 16 pixels through an 8-deep FIFO
      do_reset();
      for (int i = 1; i <= 4; i++) push(24'(i));
      idle();
      newframe();
      for (int k = 1; k <= 16; k++) begin
         cyc(k <= 12, 24'(k + 4), 1'b1, 1'b0, 1'b0);
         chk("frame_px", oREAD_DATA, 32'(k));
      end
      cyc(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
      chk("frame_err", 32'(oFrameErr), 32'h0);
      chk("frame_hold", oREAD_DATA, 32'h10);
      chk("frame_level", 32'(oLevel), 32'h0);

      // overflow: words 9 and 10 are dropped
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         push(24'h100 + 24'(i));
         if (i == 8) begin
            chk("full_ready", 32'(wr_ready), 32'h0);
            chk("full_level8", 32'(oLevel), 32'd8);
         end
      end
      chk("full_level", 32'(oLevel), 32'd8);
      newframe();
      for (int k = 1; k <= 8; k++) begin
         req();
         chk("full_px", oREAD_DATA, 32'h100 + 32'(k));
      end
      req();
      chk("full_lost", oREAD_DATA, FILLW);
      chk("full_unr", 32'(oUnderrun), 32'h1);

      // underrun after 5 pixels, 10 words discarded, back to WAIT_FRAME
      do_reset();
      for (int i = 1; i <= 5; i++) push(24'h200 + 24'(i));
      idle();
      newframe();
      for (int k = 1; k <= 5; k++) begin
         req();
         chk("unr_px", oREAD_DATA, 32'h200 + 32'(k));
      end
      req();
      chk("unr_fill", oREAD_DATA, FILLW);
      chk("unr_flag", 32'(oUnderrun), 32'h1);
      for (int i = 1; i <= 10; i++) push(24'h300 + 24'(i));
      idle();
      idle();
      idle();
      chk("unr_drained", 32'(oLevel), 32'h0);
      push(24'h000055);
      push(24'h000066);
      newframe();
      req();
      chk("unr_resume0", oREAD_DATA, 32'h55);
      req();
      chk("unr_resume1", oREAD_DATA, 32'h66);
      chk("unr_sticky", 32'(oUnderrun), 32'h1);

      // short frame: 12 pixels then end of frame
      do_reset();
      for (int i = 1; i <= 4; i++) push(24'h400 + 24'(i));
      idle();
      newframe();
      for (int k = 1; k <= 12; k++) begin
         cyc(k <= 8, 24'h400 + 24'(k + 4), 1'b1, 1'b0, 1'b0);
         chk("short_px", oREAD_DATA, 32'h400 + 32'(k));
      end
      cyc(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
      chk("short_err", 32'(oFrameErr), 32'h1);
      idle();
      idle();
      chk("short_sticky", 32'(oFrameErr), 32'h1);
      chk("short_nounr", 32'(oUnderrun), 32'h0);

      // asynchronous reset in the middle of a frame
      do_reset();
      for (int i = 1; i <= 8; i++) push(24'h500 + 24'(i));
      idle();
      newframe();
      req();
      req();
      req();
      chk("mid_px", oREAD_DATA, 32'h503);
      chk("mid_level", 32'(oLevel), 32'd5);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_level", 32'(oLevel), 32'h0);
      chk("mid_rst_data", oREAD_DATA, 32'h0);
      @(negedge CLK_33);
      reset = 1'b0;
      @(negedge CLK_33);
      for (int i = 1; i <= 3; i++) push(24'h600 + 24'(i));
      newframe();
      req();
      chk("mid_waitfill", oREAD_DATA, FILLW);
      push(24'h604);
      idle();
      idle();
      newframe();
      req();
      chk("mid_restart", oREAD_DATA, 32'h601);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
